pwm_deadtime: RTL and testbench

Complementary-output dead-time generator that sits directly downstream of `pwm_core`. It consumes the single-ended `pwm_out` and drives a high-side/low-side gate pair for a half-bridge. Both gates are held low for a programmable number of clock cycles around every edge, so the two switches are never on together. A latched fault forces both gates off.

---
 rtl/pwm_deadtime.sv | 116 +++++++++++
 tb/tb_pwm_deadtime.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_deadtime.sv
// Half-bridge dead-time generator: splits pwm_in into non-overlapping hi/lo gates with a dead band at every edge.
// Gates react one edge after pwm_q changes, plus dead_time cycles; no backpressure; a latched fault holds both gates off.
module pwm_deadtime #(
   parameter int WIDTH_DT = 8
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                enable,
   input  logic                pwm_in,
   input  logic [WIDTH_DT-1:0] dead_time,
   input  logic                fault,
   input  logic                fault_clr,
   output logic                pwm_hi,
   output logic                pwm_lo,
   output logic                dead_active,
   output logic                fault_latched
);

   typedef enum logic [4:0] {
      IDLE = 5'b00001,
      DT_H = 5'b00010,
      HIGH = 5'b00100,
      DT_L = 5'b01000,
      LOW  = 5'b10000
   } state_t;

   localparam logic [WIDTH_DT-1:0] CNT_ONE = WIDTH_DT'(1);

   state_t              state;
   state_t              state_nxt;
   logic                pwm_q;
   logic [WIDTH_DT-1:0] cnt;
   logic [WIDTH_DT-1:0] cnt_nxt;
   logic                fault_nxt;
   logic                go_hi;
   logic                go_lo;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state         <= IDLE;
         pwm_q         <= 1'b0;
         cnt           <= '0;
         fault_latched <= 1'b0;
      end else begin
         state         <= state_nxt;
         pwm_q         <= pwm_in;
         cnt           <= cnt_nxt;
         fault_latched <= fault_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      fault_nxt = fault_latched;
      go_hi     = 1'b0;
      go_lo     = 1'b0;

      if (fault) begin
         fault_nxt = 1'b1;
      end else if (fault_clr) begin
         fault_nxt = 1'b0;
      end

      // Shutdown uses the latch value from before this edge, so a clear takes one extra cycle to restart.
      if (fault || !enable || fault_latched) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (pwm_q) go_hi = 1'b1;
               else       go_lo = 1'b1;
            end
            HIGH: begin
               if (!pwm_q) go_lo = 1'b1;
            end
            LOW: begin
               if (pwm_q) go_hi = 1'b1;
            end
            DT_H: begin
               if (!pwm_q)          state_nxt = LOW;
               else if (cnt == '0)  state_nxt = HIGH;
               else                 cnt_nxt   = cnt - CNT_ONE;
            end
            DT_L: begin
               if (pwm_q)           state_nxt = HIGH;
               else if (cnt == '0)  state_nxt = LOW;
               else                 cnt_nxt   = cnt - CNT_ONE;
            end
            default: state_nxt = IDLE;
         endcase

         // dead_time is sampled only here, when a band is entered.
         if (go_hi) begin
            if (dead_time == '0) begin
               state_nxt = HIGH;
            end else begin
               state_nxt = DT_H;
               cnt_nxt   = dead_time - CNT_ONE;
            end
         end else if (go_lo) begin
            if (dead_time == '0) begin
               state_nxt = LOW;
            end else begin
               state_nxt = DT_L;
               cnt_nxt   = dead_time - CNT_ONE;
            end
         end
      end
   end

   assign pwm_hi      = (state == HIGH);
   assign pwm_lo      = (state == LOW);
   assign dead_active = (state == DT_H) || (state == DT_L);

endmodule

// File: tb/tb_pwm_deadtime.sv
// Scoreboard bench for pwm_deadtime: a run-length reference model predicts the gate outputs for every clock edge.
module tb_pwm_deadtime;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       enable;
   logic       pwm_in;
   logic [7:0] dead_time;
   logic       fault;
   logic       fault_clr;
   logic       pwm_hi;
   logic       pwm_lo;
   logic       dead_active;
   logic       fault_latched;

   always #5 clk = ~clk;

   pwm_deadtime #(.WIDTH_DT(8)) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .enable        (enable),
      .pwm_in        (pwm_in),
      .dead_time     (dead_time),
      .fault         (fault),
      .fault_clr     (fault_clr),
      .pwm_hi        (pwm_hi),
      .pwm_lo        (pwm_lo),
      .dead_active   (dead_active),
      .fault_latched (fault_latched)
   );

   int         checks = 0;
   int         errors = 0;
   logic [3:0] exp_q[$];
   logic [3:0] mon_e;

   // Reference model state: the FSM input seen at the next edge, the fault latch,
   // and the current run of equal pwm values since the last shutdown.
   logic m_q;
   logic m_lat;
   logic m_valid;
   logic m_val;
   logic m_direct;
   int   m_len;
   int   m_dt;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_q      = 1'b0;
      m_lat    = 1'b0;
      m_valid  = 1'b0;
      m_val    = 1'b0;
      m_direct = 1'b0;
      m_len    = 0;
      m_dt     = 0;
   endtask

   // Called just after a falling edge; drives inputs, predicts the next rising edge, returns at the following falling edge.
   task automatic step(input logic en, input logic pin, input int dt, input logic f, input logic fc);
      logic       active;
      logic       direct;
      logic       on;
      logic [3:0] e;
      enable    = en;
      pwm_in    = pin;
      dead_time = 8'(dt);
      fault     = f;
      fault_clr = fc;

      active = en && !f && !m_lat;
      if (!active) begin
         m_valid = 1'b0;
      end else if (m_valid && (m_q == m_val)) begin
         m_len++;
      end else begin
         // A run skips its band when the previous run was still inside its own band.
         direct   = m_valid && !m_direct && (m_len <= m_dt);
         m_val    = m_q;
         m_len    = 1;
         m_dt     = dt;
         m_direct = direct;
         m_valid  = 1'b1;
      end
      on = active && (m_direct || (m_len > m_dt));
      if (f)       m_lat = 1'b1;
      else if (fc) m_lat = 1'b0;
      e   = {on && m_val, on && !m_val, active && !on, m_lat};
      m_q = pin;

      @(posedge clk);
      exp_q.push_back(e);
      @(negedge clk);
   endtask

   task automatic count_steps(input int n, input int period, input int duty, input int dt,
                              output int h, output int l, output int d);
      h = 0;
      l = 0;
      d = 0;
      for (int i = 0; i < n; i++) begin
         step(1'b1, (i % period) < duty, dt, 1'b0, 1'b0);
         h += int'(pwm_hi);
         l += int'(pwm_lo);
         d += int'(dead_active);
      end
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         check("scoreboard", {28'd0, pwm_hi, pwm_lo, dead_active, fault_latched}, {28'd0, mon_e});
         check("exclusive", {31'd0, pwm_hi & pwm_lo}, 32'd0);
      end
   end

   initial begin
      int  h;
      int  l;
      int  d;
      int  dsum;
      logic pin;
      int  dtr;

      reset_n   = 1'b0;
      enable    = 1'b0;
      pwm_in    = 1'b0;
      dead_time = 8'd0;
      fault     = 1'b0;
      fault_clr = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      check("reset_state", {28'd0, pwm_hi, pwm_lo, dead_active, fault_latched}, 32'd0);
      reset_n = 1'b1;

      // Basic dead band: period 10, duty 4, dead_time 2.
      count_steps(30, 10, 4, 2, h, l, d);
      count_steps(10, 10, 4, 2, h, l, d);
      check("basic_hi", h, 2);
      check("basic_lo", l, 4);
      check("basic_dead", d, 4);

      // Zero dead time.
      count_steps(30, 10, 4, 0, h, l, d);
      count_steps(10, 10, 4, 0, h, l, d);
      check("zero_hi", h, 4);
      check("zero_lo", l, 6);
      check("zero_dead", d, 0);

      // Short pulse swallowed while in LOW.
      count_steps(15, 1, 0, 3, h, l, d);
      h = 0;
      l = 0;
      for (int i = 0; i < 10; i++) begin
         step(1'b1, (i == 2) || (i == 3), 3, 1'b0, 1'b0);
         h += int'(pwm_hi);
         l += int'(pwm_lo);
      end
      check("short_hi", h, 0);
      check("short_lo", l, 8);

      // Fault during HIGH, clear with and without a coincident fault.
      count_steps(20, 1, 1, 2, h, l, d);
      step(1'b1, 1'b1, 2, 1'b1, 1'b0);
      check("fault_shutdown", {28'd0, pwm_hi, pwm_lo, dead_active, fault_latched}, 32'h1);
      step(1'b1, 1'b1, 2, 1'b1, 1'b1);
      check("fault_wins_clr", {28'd0, pwm_hi, pwm_lo, dead_active, fault_latched}, 32'h1);
      step(1'b1, 1'b1, 3, 1'b0, 1'b1);
      check("fault_cleared", {28'd0, pwm_hi, pwm_lo, dead_active, fault_latched}, 32'h0);
      for (int j = 0; j < 3; j++) begin
         step(1'b1, 1'b1, 3, 1'b0, 1'b0);
         check("restart_band", {28'd0, pwm_hi, pwm_lo, dead_active, fault_latched}, 32'h2);
      end
      step(1'b1, 1'b1, 3, 1'b0, 1'b0);
      check("restart_high", {28'd0, pwm_hi, pwm_lo, dead_active, fault_latched}, 32'h8);

      // Enable dropped mid-pulse.
      count_steps(5, 1, 1, 3, h, l, d);
      step(1'b0, 1'b1, 3, 1'b0, 1'b0);
      check("enable_drop", {28'd0, pwm_hi, pwm_lo, dead_active, fault_latched}, 32'h0);

      // Asynchronous reset in the middle of a DT_H band.
      count_steps(15, 1, 0, 4, h, l, d);
      step(1'b1, 1'b1, 4, 1'b0, 1'b0);
      step(1'b1, 1'b1, 4, 1'b0, 1'b0);
      check("in_dt_h", {28'd0, pwm_hi, pwm_lo, dead_active, fault_latched}, 32'h2);
      #2 reset_n = 1'b0;
      #1 check("async_reset", {28'd0, pwm_hi, pwm_lo, dead_active, fault_latched}, 32'h0);
      @(negedge clk);
      reset_n = 1'b1;
      model_reset();
      step(1'b1, 1'b0, 4, 1'b0, 1'b0);

      // Dead-time change during a DT_L band.
      count_steps(20, 1, 1, 4, h, l, d);
      step(1'b1, 1'b0, 4, 1'b0, 1'b0);
      step(1'b1, 1'b0, 4, 1'b0, 1'b0);
      dsum = int'(dead_active);
      count_steps(9, 1, 0, 1, h, l, d);
      check("band_kept_4", dsum + d, 4);
      count_steps(10, 1, 1, 1, h, l, d);
      check("next_band_1", d, 1);
      check("next_band_hi", h, 8);

      // Randomized traffic.
      pin = 1'b0;
      dtr = 2;
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 3) == 0) pin = ~pin;
         if ($urandom_range(0, 30) == 0) dtr = int'($urandom_range(0, 5));
         step($urandom_range(0, 40) != 0, pin, dtr,
              $urandom_range(0, 60) == 0, $urandom_range(0, 8) == 0);
      end

      #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
